// File: rtl/timer_ctrl.sv
// Bus-side register front end for the millisecond timer: period/control/status
// registers, timer load strobes, sticky expiry flag, level irq and overrun count.
module timer_ctrl #(
    parameter logic [7:0] RELOAD_DEFAULT = 8'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] addr,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    input  logic       timer_expired,
    output logic [7:0] count_out,
    output logic       count_write,
    output logic       irq
);

    localparam logic [1:0] A_PERIOD  = 2'd0;
    localparam logic [1:0] A_CTRL    = 2'd1;
    localparam logic [1:0] A_STATUS  = 2'd2;
    localparam logic [1:0] A_OVERRUN = 2'd3;

    logic [7:0] period;
    logic [7:0] overrun;
    logic       ie;
    logic       periodic;
    logic       flag;
    logic       running;
    logic       cw_q;

    logic       wr_period;
    logic       wr_ctrl;
    logic       wr_status;
    logic       wr_ovr;
    logic       periodic_eff;
    logic       reload;
    logic [7:0] rd_mux;

    always_comb begin
        wr_period = wr_en && (addr == A_PERIOD);
        wr_ctrl   = wr_en && (addr == A_CTRL);
        wr_status = wr_en && (addr == A_STATUS);
        wr_ovr    = wr_en && (addr == A_OVERRUN);
        // A CTRL write landing with an expiry decides whether that expiry reloads.
        periodic_eff = wr_ctrl ? wr_data[1] : periodic;
        reload       = timer_expired && periodic_eff;
        unique case (addr)
            A_PERIOD: rd_mux = period;
            A_CTRL:   rd_mux = {6'd0, periodic, ie};
            A_STATUS: rd_mux = {6'd0, running, flag};
            default:  rd_mux = overrun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            period    <= RELOAD_DEFAULT;
            count_out <= RELOAD_DEFAULT;
            ie        <= 1'b0;
            periodic  <= 1'b0;
            flag      <= 1'b0;
            running   <= 1'b0;
            overrun   <= 8'd0;
            cw_q      <= 1'b0;
            irq       <= 1'b0;
            rd_data   <= 8'd0;
        end else begin
            if (wr_period) period <= wr_data;
            if (wr_ctrl) begin
                ie       <= wr_data[0];
                periodic <= wr_data[1];
            end

            // A PERIOD write and a reload collapse into one load carrying wr_data.
            cw_q <= wr_period || reload;
            if (wr_period)   count_out <= wr_data;
            else if (reload) count_out <= period;

            if (wr_period)                          running <= 1'b1;
            else if (timer_expired && !periodic_eff) running <= 1'b0;

            if (timer_expired)               flag <= 1'b1;
            else if (wr_status && wr_data[0]) flag <= 1'b0;

            if (wr_ovr)
                overrun <= 8'd0;
            else if (timer_expired && flag && (overrun != 8'hFF))
                overrun <= overrun + 8'd1;

            irq <= flag & ie;
            if (rd_en) rd_data <= rd_mux;
        end
    end

    // Gating keeps a strobe from escaping during the reset cycle itself.
    assign count_write = cw_q & reset_n;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl with hand-computed expectations.
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] addr;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       timer_expired;
    logic [7:0] count_out;
    logic       count_write;
    logic       irq;

    int errors = 0;
    int checks = 0;
    int cw_cnt = 0;
    int cw_base;
    logic [7:0] v;

    timer_ctrl #(.RELOAD_DEFAULT(8'd0)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wr_data(wr_data), .rd_data(rd_data), .timer_expired(timer_expired),
        .count_out(count_out), .count_write(count_write), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (count_write === 1'b1) cw_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        addr = a; wr_data = d; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        addr = a; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        d = rd_data;
    endtask

    task automatic pulse();
        timer_expired = 1'b1;
        step();
        timer_expired = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; addr = 2'd0; wr_en = 1'b0; rd_en = 1'b0;
        wr_data = 8'd0; timer_expired = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // 1: reset state
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_irq", {7'd0, irq}, 8'h00);
        chk("rst_count_out", count_out, 8'h00);
        rd(2'd0, v); chk("rst_period", v, 8'h00);
        rd(2'd1, v); chk("rst_ctrl", v, 8'h00);
        rd(2'd2, v); chk("rst_status", v, 8'h00);
        rd(2'd3, v); chk("rst_overrun", v, 8'h00);
        chk("rst_no_cw", 8'(cw_cnt), 8'd0);

        // 2: PERIOD write
        wr(2'd0, 8'd5);
        chk("p5_cw", {7'd0, count_write}, 8'h01);
        chk("p5_count_out", count_out, 8'd5);
        step();
        chk("p5_cw_drop", {7'd0, count_write}, 8'h00);
        rd(2'd2, v); chk("p5_status", v, 8'h02);
        chk("p5_cw_cnt", 8'(cw_cnt), 8'd1);
        step();
        chk("rd_hold", rd_data, 8'h02);

        // 3: one-shot expiry with irq
        wr(2'd1, 8'h01);
        cw_base = cw_cnt;
        pulse();
        chk("os_irq_n1", {7'd0, irq}, 8'h00);
        step();
        chk("os_irq_n2", {7'd0, irq}, 8'h01);
        rd(2'd2, v); chk("os_status", v, 8'h01);
        wr(2'd2, 8'h01);
        step();
        chk("os_irq_clr", {7'd0, irq}, 8'h00);
        chk("os_no_cw", 8'(cw_cnt - cw_base), 8'd0);
        rd(2'd3, v); chk("os_overrun", v, 8'h00);

        // 4: periodic reloads and overrun
        wr(2'd1, 8'h03);
        wr(2'd0, 8'd3);
        step();
        cw_base = cw_cnt;
        for (int i = 0; i < 3; i++) begin
            pulse();
            chk("per_cw", {7'd0, count_write}, 8'h01);
            chk("per_count_out", count_out, 8'd3);
            step();
        end
        chk("per_cw_cnt", 8'(cw_cnt - cw_base), 8'd3);
        rd(2'd3, v); chk("per_overrun2", v, 8'd2);
        rd(2'd2, v); chk("per_status", v, 8'h03);
        for (int i = 0; i < 300; i++) begin
            pulse();
            step();
        end
        rd(2'd3, v); chk("ovr_sat", v, 8'hFF);
        wr(2'd3, 8'h00);
        rd(2'd3, v); chk("ovr_clr", v, 8'h00);

        // 5: simultaneous events
        wr(2'd2, 8'h01);
        step();
        cw_base = cw_cnt;
        addr = 2'd0; wr_data = 8'd9; wr_en = 1'b1; timer_expired = 1'b1;
        step();
        wr_en = 1'b0; timer_expired = 1'b0;
        chk("sim_cw", {7'd0, count_write}, 8'h01);
        chk("sim_count_out", count_out, 8'd9);
        step();
        chk("sim_cw_once", 8'(cw_cnt - cw_base), 8'd1);
        rd(2'd2, v); chk("sim_status", v, 8'h03);
        rd(2'd0, v); chk("sim_period", v, 8'd9);
        rd(2'd3, v); chk("sim_ovr0", v, 8'd0);
        addr = 2'd2; wr_data = 8'h01; wr_en = 1'b1; timer_expired = 1'b1;
        step();
        wr_en = 1'b0; timer_expired = 1'b0;
        rd(2'd2, v); chk("clr_vs_set", v, 8'h03);
        rd(2'd3, v); chk("clr_vs_set_ovr", v, 8'd1);
        cw_base = cw_cnt;
        addr = 2'd1; wr_data = 8'h01; wr_en = 1'b1; timer_expired = 1'b1;
        step();
        wr_en = 1'b0; timer_expired = 1'b0;
        chk("perclr_no_cw", {7'd0, count_write}, 8'h00);
        rd(2'd2, v); chk("perclr_status", v, 8'h01);
        chk("perclr_cw_cnt", 8'(cw_cnt - cw_base), 8'd0);

        // 6: reset during pending reload
        wr(2'd1, 8'h03);
        cw_base = cw_cnt;
        timer_expired = 1'b1; reset_n = 1'b0;
        step();
        timer_expired = 1'b0;
        chk("rr_cw", {7'd0, count_write}, 8'h00);
        chk("rr_count_out", count_out, 8'h00);
        chk("rr_irq", {7'd0, irq}, 8'h00);
        chk("rr_rd_data", rd_data, 8'h00);
        reset_n = 1'b1;
        step();
        chk("rr_cw2", {7'd0, count_write}, 8'h00);
        rd(2'd0, v); chk("rr_period", v, 8'h00);
        rd(2'd1, v); chk("rr_ctrl", v, 8'h00);
        rd(2'd2, v); chk("rr_status", v, 8'h00);
        rd(2'd3, v); chk("rr_overrun", v, 8'h00);
        chk("rr_cw_cnt", 8'(cw_cnt - cw_base), 8'd0);

        // Reset landing on the load cycle of a PERIOD write suppresses the strobe
        wr(2'd0, 8'd7);
        reset_n = 1'b0;
        #1;
        chk("rst_gate_cw", {7'd0, count_write}, 8'h00);
        step();
        reset_n = 1'b1;
        step();
        chk("rst_gate_count_out", count_out, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
